l1_refill_ctrl: RTL and testbench

L1_REFILL_CTRL -- requirements
Module: l1_refill_ctrl

---
 rtl/l1_pkg.sv | 27 ++
 rtl/l1_refill_ctrl.sv | 97 +++++++++
 tb/tb_l1_refill_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_pkg.sv
// Shared definitions for the L1 refill controller: FSM state encoding and
// the address-split derivations used by the controller.
package l1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_e;

    // Byte-offset bits of a whole cache line.
    function automatic int calc_off(input int line_words, input int width);
        return $clog2(line_words * width / 8);
    endfunction

    // Byte-offset bits within one data word.
    function automatic int calc_boff(input int width);
        return $clog2(width / 8);
    endfunction

    // Word-select bits within one cache line.
    function automatic int calc_bw(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/l1_refill_ctrl.sv
// L1 line refill controller: accepts a miss, issues one line read to the next
// level and streams the returned beats straight into the data memory.
module l1_refill_ctrl
    import l1_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 1024,
    parameter int LINE_WORDS = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     MEM_READY,
    input  logic                     miss_val,
    input  logic [31:0]              miss_addr,
    output logic                     miss_rdy,
    output logic                     bus_req_val,
    output logic [31:0]              bus_req_addr,
    input  logic                     bus_req_ack,
    input  logic                     bus_rsp_val,
    input  logic [WIDTH-1:0]         bus_rsp_data,
    output logic                     dm_en,
    output logic                     dm_we,
    output logic [$clog2(DEPTH)-1:0] dm_addr,
    output logic [WIDTH-1:0]         dm_wdata,
    output logic                     fill_done,
    output logic                     busy
);

    localparam int OFF  = calc_off(LINE_WORDS, WIDTH);
    localparam int BOFF = calc_boff(WIDTH);
    localparam int BW   = calc_bw(LINE_WORDS);
    localparam int AW   = $clog2(DEPTH);

    refill_state_e  state_q;
    logic [31:0]    addr_q;
    logic [BW-1:0]  beat_q;
    logic           beat_fire;
    logic           unused_addr_bits;

    // The byte offset inside the line never reaches the bus or the array.
    assign unused_addr_bits = ^addr_q[OFF-1:0];

    assign miss_rdy  = (state_q == IDLE) & MEM_READY;
    assign beat_fire = (state_q == FILL) & bus_rsp_val;

    // NOTE: all state lives in one always_ff with non-blocking updates, so every
    // branch reads the pre-edge values of state_q/beat_q regardless of order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_val && miss_rdy) begin
                        addr_q  <= miss_addr;
                        beat_q  <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (bus_req_ack) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (bus_rsp_val) begin
                        beat_q <= beat_q + 1'b1;
                        // LINE_WORDS is a power of two, so all-ones is the last beat.
                        if (&beat_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_req_val  = (state_q == REQ);
    assign bus_req_addr = bus_req_val ? {addr_q[31:OFF], {OFF{1'b0}}} : 32'd0;
    assign fill_done    = (state_q == DONE);
    assign busy         = (state_q != IDLE);

    // Beats are written in the cycle they arrive; the data path is zeroed otherwise.
    assign dm_en    = beat_fire;
    assign dm_we    = beat_fire;
    assign dm_addr  = beat_fire ? {addr_q[BOFF+AW-1:OFF], beat_q} : {AW{1'b0}};
    assign dm_wdata = beat_fire ? bus_rsp_data : {WIDTH{1'b0}};

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Self-checking bench for l1_refill_ctrl: directed scenarios plus randomized
// fills compared against a line-arithmetic reference model.
module tb_l1_refill_ctrl;

    localparam int WIDTH      = 32;
    localparam int DEPTH      = 1024;
    localparam int LINE_WORDS = 4;
    localparam int AW         = $clog2(DEPTH);
    localparam int LINE_BYTES = LINE_WORDS * WIDTH / 8;

    logic             CLK;
    logic             RST_N;
    logic             MEM_READY;
    logic             miss_val;
    logic [31:0]      miss_addr;
    logic             miss_rdy;
    logic             bus_req_val;
    logic [31:0]      bus_req_addr;
    logic             bus_req_ack;
    logic             bus_rsp_val;
    logic [WIDTH-1:0] bus_rsp_data;
    logic             dm_en;
    logic             dm_we;
    logic [AW-1:0]    dm_addr;
    logic [WIDTH-1:0] dm_wdata;
    logic             fill_done;
    logic             busy;

    int vectors;
    int miscompares;

    l1_refill_ctrl #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .MEM_READY    (MEM_READY),
        .miss_val     (miss_val),
        .miss_addr    (miss_addr),
        .miss_rdy     (miss_rdy),
        .bus_req_val  (bus_req_val),
        .bus_req_addr (bus_req_addr),
        .bus_req_ack  (bus_req_ack),
        .bus_rsp_val  (bus_rsp_val),
        .bus_rsp_data (bus_rsp_data),
        .dm_en        (dm_en),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .fill_done    (fill_done),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: line-aligned bus address and array index of word k.
    function automatic logic [31:0] model_bus_addr(input logic [31:0] a);
        longint line;
        line = longint'(a) / LINE_BYTES;
        return 32'(line * LINE_BYTES);
    endfunction

    function automatic logic [AW-1:0] model_dm_addr(input logic [31:0] a, input int k);
        longint idx;
        idx = ((longint'(a) / LINE_BYTES) * LINE_WORDS + k) % DEPTH;
        return idx[AW-1:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete miss from IDLE through DONE with checks on every cycle.
    task automatic run_fill(input logic [31:0] addr, input int ack_dly,
                            input logic [31:0] pat, input bit use_pat,
                            input bit stray, input string tag);
        logic [31:0]      exp_bus;
        logic [AW-1:0]    exp_dm;
        logic [WIDTH-1:0] d;
        bit               v;
        int               k;
        int               writes;
        exp_bus = model_bus_addr(addr);
        miss_val  = 1'b1;
        miss_addr = addr;
        #1;
        vectors++;
        if (miss_rdy !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: miss_rdy=%0b busy=%0b want 1/0", tag, miss_rdy, busy);
        end
        tick();
        miss_val  = 1'b0;
        miss_addr = $urandom;
        for (int i = 0; i <= ack_dly; i++) begin
            bus_req_ack  = (i == ack_dly);
            bus_rsp_val  = stray;
            bus_rsp_data = $urandom;
            #1;
            vectors++;
            if (bus_req_val !== 1'b1 || bus_req_addr !== exp_bus) begin
                miscompares++;
                $display("FAIL %s req: val=%0b addr=%h want 1/%h", tag, bus_req_val, bus_req_addr, exp_bus);
            end
            vectors++;
            if (dm_en !== 1'b0 || miss_rdy !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s req_side: dm_en=%0b miss_rdy=%0b busy=%0b want 0/0/1", tag, dm_en, miss_rdy, busy);
            end
            tick();
        end
        bus_req_ack = 1'b0;
        k      = 0;
        writes = 0;
        for (int cyc = 0; cyc < 64 && k < LINE_WORDS; cyc++) begin
            v = use_pat ? pat[cyc % 32] : ($urandom_range(3) != 0);
            d = $urandom;
            bus_rsp_val  = v;
            bus_rsp_data = d;
            exp_dm = v ? model_dm_addr(addr, k) : '0;
            #1;
            if (dm_en === 1'b1) writes++;
            vectors++;
            if (dm_en !== v || dm_we !== v) begin
                miscompares++;
                $display("FAIL %s fill_en cyc%0d: en=%0b we=%0b want %0b", tag, cyc, dm_en, dm_we, v);
            end
            vectors++;
            if (dm_addr !== exp_dm || dm_wdata !== (v ? d : '0)) begin
                miscompares++;
                $display("FAIL %s fill_data cyc%0d: addr=%h data=%h want %h/%h", tag, cyc, dm_addr, dm_wdata, exp_dm, v ? d : '0);
            end
            vectors++;
            if (fill_done !== 1'b0 || busy !== 1'b1 || bus_req_val !== 1'b0) begin
                miscompares++;
                $display("FAIL %s fill_ctl cyc%0d: done=%0b busy=%0b req=%0b want 0/1/0", tag, cyc, fill_done, busy, bus_req_val);
            end
            tick();
            if (v) k++;
        end
        vectors++;
        if (writes !== LINE_WORDS) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d want %0d", tag, writes, LINE_WORDS);
        end
        bus_rsp_val = 1'b1;
        miss_val    = 1'b1;
        #1;
        vectors++;
        if (fill_done !== 1'b1 || miss_rdy !== 1'b0 || dm_en !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done: done=%0b miss_rdy=%0b dm_en=%0b want 1/0/0", tag, fill_done, miss_rdy, dm_en);
        end
        tick();
        miss_val    = 1'b0;
        bus_rsp_val = 1'b0;
        #1;
        vectors++;
        if (fill_done !== 1'b0 || busy !== 1'b0 || bus_req_val !== 1'b0) begin
            miscompares++;
            $display("FAIL %s post_done: done=%0b busy=%0b req=%0b want 0/0/0", tag, fill_done, busy, bus_req_val);
        end
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({miss_rdy, bus_req_val, dm_en, dm_we, fill_done, busy} !== 6'b0 ||
            bus_req_addr !== 32'd0 || dm_addr !== '0 || dm_wdata !== '0) begin
            miscompares++;
            $display("FAIL %s outputs: rdy=%0b req=%0b raddr=%h en=%0b we=%0b daddr=%h wd=%h done=%0b busy=%0b want all 0",
                     tag, miss_rdy, bus_req_val, bus_req_addr, dm_en, dm_we, dm_addr, dm_wdata, fill_done, busy);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; MEM_READY = 1'b0; miss_val = 1'b0; miss_addr = '0;
        bus_req_ack = 1'b0; bus_rsp_val = 1'b0; bus_rsp_data = '0;
        #2;
        check_all_zero("reset_early");
        miss_val = 1'b1; bus_rsp_val = 1'b1; bus_rsp_data = 32'hdead_beef; bus_req_ack = 1'b1;
        repeat (3) tick();
        check_all_zero("reset_held");
        miss_val = 1'b0; bus_rsp_val = 1'b0; bus_req_ack = 1'b0;
        RST_N = 1'b1;
        tick();
        check_all_zero("after_reset");
    endtask

    task automatic test_init_gating();
        int bad;
        bad = 0;
        miss_val  = 1'b1;
        miss_addr = 32'h0000_2040;
        for (int i = 0; i < 1024; i++) begin
            #1;
            vectors++;
            if (miss_rdy !== 1'b0 || bus_req_val !== 1'b0) begin
                miscompares++;
                if (bad < 5)
                    $display("FAIL init_gate cyc%0d: miss_rdy=%0b bus_req_val=%0b want 0/0", i, miss_rdy, bus_req_val);
                bad++;
            end
            tick();
        end
        MEM_READY = 1'b1;
        run_fill(32'h0000_2040, 0, '0, 1'b0, 1'b0, "init_release");
    endtask

    task automatic test_basic_fill();
        run_fill(32'h0000_1234, 3, 32'hffff_ffff, 1'b1, 1'b0, "basic");
    endtask

    task automatic test_bubbles();
        run_fill(32'h0000_5678, 1, 32'b1011001, 1'b1, 1'b0, "bubbles");
    endtask

    task automatic test_index_wrap();
        run_fill(32'h0000_0FFC, 0, 32'hffff_ffff, 1'b1, 1'b0, "wrap_top");
        run_fill(32'h0000_1000, 2, 32'hffff_ffff, 1'b1, 1'b0, "wrap_zero");
    endtask

    task automatic test_stray();
        miss_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_rsp_val  = 1'b1;
            bus_rsp_data = $urandom | 32'h1;
            #1;
            vectors++;
            if (dm_en !== 1'b0 || dm_we !== 1'b0 || dm_wdata !== '0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL stray_idle cyc%0d: en=%0b we=%0b wd=%h busy=%0b want 0", i, dm_en, dm_we, dm_wdata, busy);
            end
            tick();
        end
        bus_rsp_val = 1'b0;
        run_fill(32'h0000_0A50, 4, 32'hffff_ffff, 1'b1, 1'b1, "stray_req");
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] a;
        a = 32'h0000_3370;
        miss_val = 1'b1; miss_addr = a;
        tick();
        miss_val = 1'b0; bus_req_ack = 1'b1;
        tick();
        bus_req_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus_rsp_val = 1'b1; bus_rsp_data = $urandom;
            #1;
            vectors++;
            if (dm_en !== 1'b1 || dm_addr !== model_dm_addr(a, b)) begin
                miscompares++;
                $display("FAIL rst_mid beat%0d: en=%0b addr=%h want 1/%h", b, dm_en, dm_addr, model_dm_addr(a, b));
            end
            tick();
        end
        RST_N = 1'b0; MEM_READY = 1'b0;
        bus_rsp_val = 1'b1; bus_rsp_data = $urandom;
        #1;
        check_all_zero("rst_mid_async");
        repeat (2) tick();
        check_all_zero("rst_mid_held");
        RST_N = 1'b1; MEM_READY = 1'b1; bus_rsp_val = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || fill_done !== 1'b0 || miss_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_release: busy=%0b done=%0b rdy=%0b want 0/0/1", busy, fill_done, miss_rdy);
        end
        run_fill(a, 1, 32'hffff_ffff, 1'b1, 1'b0, "rst_refill");
    endtask

    task automatic test_back_to_back();
        run_fill(32'h0000_4444, 0, 32'hffff_ffff, 1'b1, 1'b0, "b2b_first");
        run_fill(32'h0000_4448, 0, 32'hffff_ffff, 1'b1, 1'b0, "b2b_same_line");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            run_fill($urandom, $urandom_range(4), '0, 1'b0, 1'($urandom_range(1)), $sformatf("rand%0d", n));
            repeat ($urandom_range(2)) tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_init_gating();
        test_basic_fill();
        test_bubbles();
        test_index_wrap();
        test_stray();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
